golomb_regular_encoder_pipe: RTL and testbench
==============================================

// Module: golomb_regular_encoder_pipe
// PURPOSE
//  Pipelined, parametrised Golomb-Rice codeword generator for JPEG-LS regular and run-interruption
//  coding. Covers both under-limit (unary+1+k LSBs) and escape (LIMIT-QBPP-1 zeros, 1, MErrval-1) cases.
//  Sits between error mapping / k computation and the bitstream packer.
//  Valid/ready handshake on both sides; running bit and escape statistics for rate monitoring.
// PARAMETERS
//  MERR_W   9   width of mapped error value MErrval
//  K_W      4   width of Golomb parameter k
//  LIMIT    32  max codeword length (2*(bpp+max(8,bpp)))
//  QBPP     8   bits of MErrval-1 sent after escape
//  CODE_W   32  codeword width (>= LIMIT)
//  LEN_W    6   codeword length width (holds LIMIT)
//  STAT_W   32  statistic counter width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       input sample valid
//  in_ready     out  1       block can accept sample
//  merrval      in   MERR_W  mapped error value
//  k            in   K_W     Golomb parameter
//  limit_adj    in   5       subtracted from LIMIT (0 regular; J+1 run interruption)
//  out_valid    out  1       codeword valid
//  out_ready    in   1       downstream accepts codeword
//  code         out  CODE_W  codeword, right-aligned; bit len-1 sent first; bits >= len are 0
//  code_len     out  LEN_W   codeword length in bits, 1..LIMIT
//  is_escape    out  1       codeword took the escape path
//  clear_stats  in   1       zero the statistic counters
//  bit_count    out  STAT_W  sum of code_len of all transferred codewords, saturating
//  esc_count    out  STAT_W  number of transferred escape codewords, saturating
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 the cycle after; out_valid, code, code_len, is_escape,
//    bit_count, esc_count = 0; all stage valids cleared. Reset mid-operation discards in-flight words.
//  - Input transfer: in_valid & in_ready; output transfer: out_valid & out_ready.
//  - Two stages, latency 2: S1 registers q = merrval>>k (k >= MERR_W -> q=0), masked LSBs,
//    effective limit L = LIMIT-limit_adj, escape = (q >= L-QBPP-1) (threshold <= 0 -> always escape).
//    S2 registers code/code_len/is_escape.
//  - Normal: code = (1<<k) | (merrval & ((1<<k)-1)); code_len = q+1+k.
//  - Escape: code = (1<<QBPP) | (merrval-1) (merrval=0 never escapes); code_len = L.
//  - Flow: stage advances when next stage empty or draining this cycle;
//    in_ready = !S1_valid | S1 advances. Full throughput 1/cycle with out_ready=1; no bubbles, no loss.
//  - While out_valid & !out_ready: code, code_len, is_escape held stable.
//  - Stats update on output transfer only; clear_stats same cycle as transfer -> clear wins (result 0).
//    Counters saturate at all-ones, never wrap.
//  - Out-of-range inputs (limit_adj > LIMIT-QBPP-1, merrval >= 2^QBPP+1 on escape): undefined code,
//    but handshake and ordering unaffected.
// STRUCTURE
//  - Shared package/include: LIMIT, QBPP, MERR_W, K_W, CODE_W, LEN_W defaults,
//    derived UNARY_MAX = LIMIT-QBPP-1.
//  - One sub-module: golomb_code_build (pure combinational S2 codeword/length builder).
//    Pipeline control, handshake and counters stay in the top.
// TESTING (LIMIT=32, QBPP=8)
//  1. merrval=5,k=1,adj=0 -> 2 cycles later code=0x3, len=4, esc=0; bit_count=4.
//  2. merrval=0,k=0 -> code=0x1, len=1. merrval=22,k=0 -> code=0x1, len=23, esc=0.
//     merrval=23,k=0 -> code=0x116, len=32, esc=1.
//  3. merrval=20,k=0,adj=3 -> L=29, escape: code=0x113, len=29; esc_count increments.
//  4. Stream 1,2,3 (k=0), out_ready=0 for 3 cycles then 1 -> exactly 2 accepted while stalled,
//     in_ready=0, outputs stable; then lens 2,3,4 in order, no gaps.
//  5. clear_stats with concurrent transfer -> bit_count=0,esc_count=0 next cycle.
//     Preload counter near max -> saturates at 0xFFFFFFFF.
//  6. Assert reset with 2 words in flight -> out_valid=0 next cycle; words never emerge;
//     first post-reset input emerges at latency 2.

Source files
------------

// File: rtl/golomb_regular_encoder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : golomb_regular_encoder_pipe_pkg
// Brief   : Shared defaults and derived constants for the JPEG-LS
//           Golomb-Rice codeword pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package golomb_regular_encoder_pipe_pkg;

  localparam int MERR_W_DEF = 9;
  localparam int K_W_DEF    = 4;
  localparam int LIMIT_DEF  = 32;
  localparam int QBPP_DEF   = 8;
  localparam int CODE_W_DEF = 32;
  localparam int LEN_W_DEF  = 6;
  localparam int STAT_W_DEF = 32;

  // Longest unary prefix allowed before the escape path takes over
  function automatic int unary_max(input int limit, input int qbpp);
    return limit - qbpp - 1;
  endfunction

  localparam int UNARY_MAX_DEF = unary_max(LIMIT_DEF, QBPP_DEF);

endpackage : golomb_regular_encoder_pipe_pkg
`default_nettype wire

// File: rtl/golomb_regular_encoder_pipe_code_build.sv
`default_nettype none
// ============================================================================
// Module  : golomb_code_build
// Brief   : Combinational second-stage builder: turns the stage-1 fields
//           (quotient, masked LSBs, effective limit, escape flag) into the
//           right-aligned codeword and its length.
// Revision: 1.0 - initial release
// ============================================================================
module golomb_code_build #(
  parameter int MERR_W = 9,
  parameter int K_W    = 4,
  parameter int QBPP   = 8,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic [MERR_W-1:0] merrval,
  input  logic [K_W-1:0]    k,
  input  logic [MERR_W-1:0] q,
  input  logic [MERR_W-1:0] lsbs,
  input  logic [LEN_W-1:0]  limit,
  input  logic              escape,
  output logic [CODE_W-1:0] code,
  output logic [LEN_W-1:0]  code_len
);

  // Sum width wide enough that q + k + 1 cannot overflow before truncation
  localparam int SW = ((MERR_W > LEN_W) ? MERR_W : LEN_W) + K_W + 1;

  logic [MERR_W-1:0] w_merr_m1;
  logic [CODE_W-1:0] w_qbpp_mask;
  logic [SW-1:0]     w_len_sum;

  assign w_merr_m1   = merrval - MERR_W'(1);
  assign w_qbpp_mask = (CODE_W'(1) << QBPP) - CODE_W'(1);
  assign w_len_sum   = SW'(q) + SW'(k) + SW'(1);

  // Escape: marker 1 followed by QBPP bits of MErrval-1; otherwise 1 then k LSBs
  always_comb begin
    code     = '0;
    code_len = '0;
    if (escape) begin
      code     = (CODE_W'(1) << QBPP) | (CODE_W'(w_merr_m1) & w_qbpp_mask);
      code_len = limit;
    end else begin
      code     = (CODE_W'(1) << k) | CODE_W'(lsbs);
      code_len = LEN_W'(w_len_sum);
    end
  end

endmodule : golomb_code_build
`default_nettype wire

// File: rtl/golomb_regular_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : golomb_regular_encoder_pipe
// Brief   : Two-stage pipelined JPEG-LS Golomb-Rice codeword generator with
//           valid/ready handshakes and saturating bit / escape statistics.
// Revision: 1.0 - initial release
// ============================================================================
module golomb_regular_encoder_pipe
  import golomb_regular_encoder_pipe_pkg::*;
#(
  parameter int MERR_W = MERR_W_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int LIMIT  = LIMIT_DEF,
  parameter int QBPP   = QBPP_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MERR_W-1:0] merrval,
  input  logic [K_W-1:0]    k,
  input  logic [4:0]        limit_adj,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code,
  output logic [LEN_W-1:0]  code_len,
  output logic              is_escape,
  input  logic              clear_stats,
  output logic [STAT_W-1:0] bit_count,
  output logic [STAT_W-1:0] esc_count
);

  // Threshold arithmetic needs headroom for a negative result
  localparam int TW       = ((LEN_W > MERR_W) ? LEN_W : MERR_W) + 2;
  localparam int THR_BASE = unary_max(LIMIT, QBPP);

  // ---------------- stage-1 combinational field extraction -----------------
  logic [MERR_W-1:0] w_q;
  logic [MERR_W-1:0] w_mask;
  logic [TW-1:0]     w_thr;
  logic [LEN_W-1:0]  w_limit;
  logic              w_escape;
  logic              w_k_big;

  assign w_k_big  = (int'(k) >= MERR_W);
  assign w_q      = w_k_big ? '0 : (merrval >> k);
  assign w_mask   = w_k_big ? '1 : ((MERR_W'(1) << k) - MERR_W'(1));
  assign w_limit  = LEN_W'(LIMIT) - LEN_W'(limit_adj);
  assign w_thr    = TW'(THR_BASE) - TW'(limit_adj);
  // Non-positive threshold means every value escapes
  assign w_escape = w_thr[TW-1] || (w_thr == '0) || (TW'(w_q) >= w_thr);

  // ---------------- pipeline registers and flow control --------------------
  logic              r_s1_valid;
  logic [MERR_W-1:0] r_s1_merrval;
  logic [K_W-1:0]    r_s1_k;
  logic [MERR_W-1:0] r_s1_q;
  logic [MERR_W-1:0] r_s1_lsbs;
  logic [LEN_W-1:0]  r_s1_limit;
  logic              r_s1_escape;

  logic              r_out_valid;
  logic [CODE_W-1:0] r_code;
  logic [LEN_W-1:0]  r_code_len;
  logic              r_is_escape;

  logic [STAT_W-1:0] r_bit_count;
  logic [STAT_W-1:0] r_esc_count;

  logic              w_s2_load;
  logic              w_out_xfer;
  logic [CODE_W-1:0] w_build_code;
  logic [LEN_W-1:0]  w_build_len;

  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign w_out_xfer = r_out_valid && out_ready;
  assign in_ready   = !reset && (!r_s1_valid || w_s2_load);

  // Stage 1: capture quotient, masked LSBs, effective limit and escape decision
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_merrval <= '0;
      r_s1_k       <= '0;
      r_s1_q       <= '0;
      r_s1_lsbs    <= '0;
      r_s1_limit   <= '0;
      r_s1_escape  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_merrval <= merrval;
        r_s1_k       <= k;
        r_s1_q       <= w_q;
        r_s1_lsbs    <= merrval & w_mask;
        r_s1_limit   <= w_limit;
        r_s1_escape  <= w_escape;
      end
    end
  end

  golomb_code_build #(
    .MERR_W (MERR_W),
    .K_W    (K_W),
    .QBPP   (QBPP),
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W)
  ) u_code_build (
    .merrval  (r_s1_merrval),
    .k        (r_s1_k),
    .q        (r_s1_q),
    .lsbs     (r_s1_lsbs),
    .limit    (r_s1_limit),
    .escape   (r_s1_escape),
    .code     (w_build_code),
    .code_len (w_build_len)
  );

  // Stage 2: register the built codeword; hold it while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_code_len  <= '0;
      r_is_escape <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_code      <= w_build_code;
      r_code_len  <= w_build_len;
      r_is_escape <= r_s1_escape;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // ---------------- rate statistics ----------------------------------------
  logic [STAT_W:0] w_bit_sum;
  logic [STAT_W:0] w_esc_sum;

  assign w_bit_sum = {1'b0, r_bit_count} + (STAT_W+1)'(r_code_len);
  assign w_esc_sum = {1'b0, r_esc_count} + (STAT_W+1)'(r_is_escape);

  // Saturating counters advanced on output transfers; clear has priority
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_bit_count <= '0;
      r_esc_count <= '0;
    end else if (w_out_xfer) begin
      r_bit_count <= w_bit_sum[STAT_W] ? '1 : w_bit_sum[STAT_W-1:0];
      r_esc_count <= w_esc_sum[STAT_W] ? '1 : w_esc_sum[STAT_W-1:0];
    end
  end

  assign out_valid = r_out_valid;
  assign code      = r_code;
  assign code_len  = r_code_len;
  assign is_escape = r_is_escape;
  assign bit_count = r_bit_count;
  assign esc_count = r_esc_count;

endmodule : golomb_regular_encoder_pipe
`default_nettype wire

// File: tb/tb_golomb_regular_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_golomb_regular_encoder_pipe
// Brief   : Directed plus randomized bench for the Golomb-Rice pipeline,
//           checked against an arithmetic reference model and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_golomb_regular_encoder_pipe;

  localparam int LIMIT = 32;
  localparam int QBPP  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  merrval = '0;
  logic [3:0]  k = '0;
  logic [4:0]  limit_adj = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] code;
  logic [5:0]  code_len;
  logic        is_escape;
  logic        clear_stats = 1'b0;
  logic [31:0] bit_count;
  logic [31:0] esc_count;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] code_s;
  logic [5:0]  code_len_s;
  logic        is_escape_s;
  logic [7:0]  bit_count_s;
  logic [7:0]  esc_count_s;

  always #5 clk = ~clk;

  golomb_regular_encoder_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .merrval(merrval), .k(k), .limit_adj(limit_adj), .out_valid(out_valid),
    .out_ready(out_ready), .code(code), .code_len(code_len), .is_escape(is_escape),
    .clear_stats(clear_stats), .bit_count(bit_count), .esc_count(esc_count)
  );

  // Narrow-counter copy on the same stream so saturation is reachable quickly
  golomb_regular_encoder_pipe #(.STAT_W(8)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .merrval(merrval), .k(k), .limit_adj(limit_adj), .out_valid(out_valid_s),
    .out_ready(out_ready), .code(code_s), .code_len(code_len_s), .is_escape(is_escape_s),
    .clear_stats(clear_stats), .bit_count(bit_count_s), .esc_count(esc_count_s)
  );

  int checks = 0;
  int failures = 0;

  int    exp_code[$];
  int    exp_len[$];
  int    exp_esc[$];
  longint tot_bits = 0;
  longint tot_esc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Reference codeword from the JPEG-LS rules, in plain integer arithmetic
  task automatic model(input int m, input int kk, input int adj,
                       output int c, output int len, output int esc);
    int lim;
    int thr;
    int q;
    lim = LIMIT - adj;
    thr = lim - QBPP - 1;
    q   = m / (1 << kk);
    if (thr <= 0 || q >= thr) begin
      esc = 1;
      c   = (1 << QBPP) + (m - 1);
      len = lim;
    end else begin
      esc = 0;
      c   = (1 << kk) + (m % (1 << kk));
      len = q + 1 + kk;
    end
  endtask

  // One clock: check counters, drive inputs, score the output, record accepts
  task automatic cycle(input logic v, input int m, input int kk, input int adj,
                       input logic ordy, input logic clr, output logic acc);
    int c;
    int len;
    int esc;
    @(negedge clk);
    chk("bit_count", 64'(bit_count), 64'(sat(tot_bits, 64'hFFFF_FFFF)));
    chk("esc_count", 64'(esc_count), 64'(sat(tot_esc, 64'hFFFF_FFFF)));
    chk("bit_count_sat8", 64'(bit_count_s), 64'(sat(tot_bits, 255)));
    chk("esc_count_sat8", 64'(esc_count_s), 64'(sat(tot_esc, 255)));
    in_valid    = v;
    merrval     = m[8:0];
    k           = kk[3:0];
    limit_adj   = adj[4:0];
    out_ready   = ordy;
    clear_stats = clr;
    #1;
    if (out_valid) begin
      if (exp_code.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("code", 64'(code), 64'(exp_code[0]));
        chk("code_len", 64'(code_len), 64'(exp_len[0]));
        chk("is_escape", 64'(is_escape), 64'(exp_esc[0]));
        if (out_ready) begin
          tot_bits += exp_len[0];
          tot_esc  += exp_esc[0];
          void'(exp_code.pop_front());
          void'(exp_len.pop_front());
          void'(exp_esc.pop_front());
        end
      end
    end
    if (clr) begin
      tot_bits = 0;
      tot_esc  = 0;
    end
    acc = in_valid && in_ready;
    if (acc) begin
      model(m, kk, adj, c, len, esc);
      exp_code.push_back(c);
      exp_len.push_back(len);
      exp_esc.push_back(esc);
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && exp_code.size() != 0; i++)
      cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("drain_timeout", 64'(exp_code.size()), 64'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    merrval  = 9'd7;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("in_ready_during_reset", 64'(in_ready), 64'd0);
      chk("out_valid_during_reset", 64'(out_valid), 64'd0);
    end
    exp_code.delete();
    exp_len.delete();
    exp_esc.delete();
    tot_bits = 0;
    tot_esc  = 0;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_code", 64'(code), 64'd0);
    chk("rst_code_len", 64'(code_len), 64'd0);
    chk("rst_is_escape", 64'(is_escape), 64'd0);
    chk("rst_bit_count", 64'(bit_count), 64'd0);
    chk("rst_esc_count", 64'(esc_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    int   m;
    int   kk;
    int   adj;

    do_reset(3);

    // Basic codeword and latency of two
    cycle(1'b1, 5, 1, 0, 1'b1, 1'b0, acc);
    chk("t1_accept", 64'(acc), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t1_lat_not_yet", 64'(out_valid), 64'd0);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t1_lat_two", 64'(out_valid), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t1_bit_count", 64'(bit_count), 64'd4);

    // Zero value, longest unary, first escape
    cycle(1'b1, 0, 0, 0, 1'b1, 1'b0, acc);
    cycle(1'b1, 22, 0, 0, 1'b1, 1'b0, acc);
    cycle(1'b1, 23, 0, 0, 1'b1, 1'b0, acc);
    drain();

    // Run-interruption limit adjustment forces escape at a lower quotient
    cycle(1'b1, 20, 0, 3, 1'b1, 1'b0, acc);
    drain();
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t3_esc_count", 64'(esc_count), 64'd2);

    // Back-pressure: two words fit while stalled, then drain without gaps
    n = 0;
    cycle(1'b1, 1, 0, 0, 1'b0, 1'b0, acc); n += int'(acc);
    cycle(1'b1, 2, 0, 0, 1'b0, 1'b0, acc); n += int'(acc);
    cycle(1'b1, 3, 0, 0, 1'b0, 1'b0, acc); n += int'(acc);
    chk("t4_in_ready_stalled", 64'(in_ready), 64'd0);
    chk("t4_accepted_stalled", 64'(n), 64'd2);
    cycle(1'b1, 3, 0, 0, 1'b1, 1'b0, acc);
    chk("t4_accept_on_release", 64'(acc), 64'd1);
    chk("t4_out_valid_0", 64'(out_valid), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t4_out_valid_1", 64'(out_valid), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t4_out_valid_2", 64'(out_valid), 64'd1);
    drain();

    // Clear concurrent with a transfer wins
    cycle(1'b1, 9, 2, 0, 1'b1, 1'b0, acc);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b1, acc);
    chk("t5_xfer_with_clear", 64'(out_valid), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t5_bit_count_cleared", 64'(bit_count), 64'd0);
    chk("t5_esc_count_cleared", 64'(esc_count), 64'd0);

    // Randomized stream with random back-pressure
    for (int i = 0; i < 400; i++) begin
      kk  = $urandom_range(0, 10);
      adj = $urandom_range(0, 23);
      m   = $urandom_range((adj == 23) ? 1 : 0, 256);
      cycle(($urandom_range(0, 3) != 0), m, kk, adj, ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    drain();
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    if (tot_bits >= 255)
      chk("t5_sat8_bits", 64'(bit_count_s), 64'hFF);
    chk("t5_wide_bits", 64'(bit_count), 64'(tot_bits));

    // Reset with two words in flight discards them
    cycle(1'b1, 4, 0, 0, 1'b0, 1'b0, acc);
    cycle(1'b1, 6, 0, 0, 1'b0, 1'b0, acc);
    do_reset(1);
    cycle(1'b1, 11, 1, 0, 1'b1, 1'b0, acc);
    chk("t6_accept", 64'(acc), 64'd1);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t6_lat_not_yet", 64'(out_valid), 64'd0);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t6_lat_two", 64'(out_valid), 64'd1);
    chk("t6_code", 64'(code), 64'h3);
    chk("t6_len", 64'(code_len), 64'd7);
    drain();
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_golomb_regular_encoder_pipe
`default_nettype wire
